// File: rtl/lfsr_fifo_writer_if.sv
// lfsr_fifo_writer_if: writer bus (slave=writer: start/num_words/lfsr_count/full in; wr_en/wr_data/wr_count/stall_cnt/busy/done out)
interface lfsr_fifo_writer_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W = 16
);
  logic start;
  logic [CNT_W-1:0] num_words;
  logic [DATA_W-1:0] lfsr_count;
  logic full;
  logic wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0] wr_count;
  logic [CNT_W-1:0] stall_cnt;
  logic busy;
  logic done;
  modport master (
    output start, num_words, lfsr_count, full,
    input wr_en, wr_data, wr_count, stall_cnt, busy, done
  );
  modport slave (
    input start, num_words, lfsr_count, full,
    output wr_en, wr_data, wr_count, stall_cnt, busy, done
  );
endinterface

// File: rtl/lfsr_fifo_writer.sv
// lfsr_fifo_writer: bursts lfsr_count into a FIFO with lfsr-seeded gaps, honours full, counts writes/stalls, pulses done (ports: clk, rst, bus slave)
module lfsr_fifo_writer #(
  parameter int DATA_W = 8,
  parameter int BURST_LEN = 16,
  parameter int CNT_W = 16,
  parameter logic [DATA_W-1:0] GAP_MASK = 'h07
) (
  input logic clk,
  input logic rst,
  lfsr_fifo_writer_if.slave bus
);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] BL = BW'(BURST_LEN);
  typedef enum logic [1:0] {IDLE, BURST, GAP, FINISH} state_t;
  state_t state;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] wr_count;
  logic [CNT_W-1:0] stall_cnt;
  logic [BW-1:0] burst_cnt;
  logic [DATA_W-1:0] gap_cnt;
  logic wr_en;
  assign wr_en = state == BURST && !bus.full;
  assign bus.wr_en = wr_en;
  assign bus.wr_data = bus.lfsr_count;
  assign bus.wr_count = wr_count;
  assign bus.stall_cnt = stall_cnt;
  assign bus.busy = state != IDLE;
  assign bus.done = state == FINISH;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      target <= '0;
      wr_count <= '0;
      stall_cnt <= '0;
      burst_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          target <= bus.num_words;
          wr_count <= '0;
          stall_cnt <= '0;
          burst_cnt <= '0;
          state <= bus.num_words != '0 ? BURST : FINISH;
        end
        BURST: if (!wr_en) begin
          stall_cnt <= &stall_cnt ? stall_cnt : stall_cnt + 1'b1;
        end else begin
          wr_count <= wr_count + 1'b1;
          burst_cnt <= burst_cnt + 1'b1;
          if (wr_count + 1'b1 == target) state <= FINISH;
          else if (burst_cnt + 1'b1 == BL) begin
            gap_cnt <= bus.lfsr_count & GAP_MASK;
            state <= GAP;
          end
        end
        GAP: if (gap_cnt == '0) begin
          burst_cnt <= '0;
          state <= BURST;
        end else gap_cnt <= gap_cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_fifo_writer.sv
// tb_lfsr_fifo_writer: directed and random stimulus checked every cycle against a count-based model
module tb_lfsr_fifo_writer;
  logic clk = 0;
  logic rst = 1;
  lfsr_fifo_writer_if #(.DATA_W(8), .CNT_W(16)) bus ();
  lfsr_fifo_writer #(.DATA_W(8), .BURST_LEN(16), .CNT_W(16), .GAP_MASK(8'h07)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  int vec = 0;
  int errs = 0;
  bit chk_en = 0;
  bit m_active = 0;
  bit m_done = 0;
  int m_left = 0;
  int m_blen = 0;
  int m_gap = 0;
  int m_cnt = 0;
  int m_stall = 0;
  int n_wr = 0;
  int n_done = 0;
  int n_gap = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_done = 0; m_left = 0; m_blen = 0; m_gap = 0; m_cnt = 0; m_stall = 0;
    end else if (m_done) m_done = 0;
    else if (!m_active) begin
      if (bus.start) begin
        m_cnt = 0; m_stall = 0; m_blen = 0; m_gap = 0;
        if (bus.num_words == 0) m_done = 1;
        else begin m_active = 1; m_left = bus.num_words; end
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) m_blen = 0;
    end else if (bus.full) m_stall = m_stall < 65535 ? m_stall + 1 : 65535;
    else begin
      m_cnt++; m_left--; m_blen++;
      if (m_left == 0) begin m_active = 0; m_done = 1; end
      else if (m_blen == 16) m_gap = (bus.lfsr_count & 8'h07) + 1;
    end
  end
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("wr_en", bus.wr_en, m_active && m_gap == 0 && !bus.full);
      if (bus.wr_en) chk("wr_data", bus.wr_data, bus.lfsr_count);
      chk("busy", bus.busy, m_active || m_done);
      chk("done", bus.done, m_done);
      chk("wr_count", bus.wr_count, m_cnt);
      chk("stall_cnt", bus.stall_cnt, m_stall);
      if (bus.wr_en) n_wr++;
      if (bus.done) n_done++;
      if (bus.busy && !bus.wr_en && !bus.done && !bus.full) n_gap++;
    end
  end
  task automatic go(input logic s, input int nw, input logic f, input int l);
    @(negedge clk);
    bus.start = s;
    bus.num_words = 16'(nw);
    bus.full = f;
    bus.lfsr_count = l < 0 ? 8'($urandom) : 8'(l);
    #3;
  endtask
  task automatic clr();
    n_wr = 0; n_done = 0; n_gap = 0;
  endtask
  task automatic wait_done(input string nm, input logic restart, input int l);
    int k = 0;
    while (n_done == 0 && k < 400) begin
      go(restart, 5, 0, l);
      k++;
    end
    chk({nm, " done_seen"}, n_done > 0, 1);
    go(0, 0, 0, l);
  endtask
  initial begin
    bus.start = 0; bus.num_words = 0; bus.full = 0; bus.lfsr_count = 0;
    go(0, 0, 0, -1);
    go(0, 0, 0, -1);
    rst = 0;
    chk_en = 1;
    go(0, 0, 0, -1);
    chk("reset wr_count", bus.wr_count, 0);
    chk("reset busy", bus.busy, 0);
    clr(); go(1, 5, 0, -1); wait_done("t1", 0, -1);
    chk("t1 writes", n_wr, 5); chk("t1 gaps", n_gap, 0);
    chk("t1 wr_count", bus.wr_count, 5); chk("t1 stall", bus.stall_cnt, 0); chk("t1 model", m_cnt, 5);
    clr(); go(1, 20, 0, 3); wait_done("t2", 0, 3);
    chk("t2 writes", n_wr, 20); chk("t2 gap cycles", n_gap, 4); chk("t2 wr_count", bus.wr_count, 20);
    clr(); go(1, 10, 0, -1);
    for (int k = 0; k < 50 && n_wr < 2; k++) go(0, 0, 0, -1);
    for (int k = 0; k < 3; k++) go(0, 0, 1, -1);
    wait_done("t3", 0, -1);
    chk("t3 writes", n_wr, 10); chk("t3 stall", bus.stall_cnt, 3); chk("t3 wr_count", bus.wr_count, 10);
    clr(); go(1, 0, 0, -1); go(0, 0, 0, -1);
    chk("t4 done", bus.done, 1); chk("t4 writes", n_wr, 0); chk("t4 wr_count", bus.wr_count, 0);
    go(0, 0, 0, -1);
    chk("t4 done once", n_done, 1);
    clr(); go(1, 16, 0, -1);
    for (int k = 0; k < 50 && n_wr < 7; k++) go(0, 0, 0, -1);
    rst = 1; go(0, 0, 0, -1); rst = 0; go(0, 0, 0, -1);
    chk("t5 wr_en", bus.wr_en, 0); chk("t5 busy", bus.busy, 0); chk("t5 wr_count", bus.wr_count, 0);
    clr(); go(1, 3, 0, -1); wait_done("t5b", 0, -1);
    chk("t5 writes", n_wr, 3); chk("t5 final", bus.wr_count, 3);
    clr(); go(1, 40, 0, -1); wait_done("t6", 1, -1);
    go(0, 0, 0, -1);
    chk("t6 single done", n_done, 1); chk("t6 writes", n_wr, 40); chk("t6 wr_count", bus.wr_count, 40);
    for (int k = 0; k < 4000; k++) begin
      rst = $urandom_range(0, 399) == 0;
      go($urandom_range(0, 19) == 0, $urandom_range(0, 40), $urandom_range(0, 3) == 0, -1);
    end
    rst = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
